// File: rtl/stm32_if_pkg.sv
// Shared definitions for the RX/TX sequencer and the STM32 bus interface:
// state encoding, NCO frequency word width and its power-on default.
package stm32_if_pkg;

   localparam int unsigned FREQ_W = 22;
   localparam logic [FREQ_W-1:0] FREQ_DEFAULT = 22'd620407;

   localparam int unsigned TMR_W  = 16;
   localparam int unsigned WDOG_W = 24;

   typedef enum logic [2:0] {
      StRx       = 3'd0,
      StRxMute   = 3'd1,
      StTxSettle = 3'd2,
      StTx       = 3'd3,
      StTxDrain  = 3'd4,
      StRxSettle = 3'd5
   } seq_state_e;

   // Transitional states, where the RF path is being reconfigured.
   function automatic logic is_busy(input seq_state_e s);
      return (s == StRxMute) || (s == StTxSettle) || (s == StTxDrain) || (s == StRxSettle);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; holds at zero and flags it. Drives the mute/settle
// dwell times of the sequencer.
module seq_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk_in,
   input  logic         reset_in,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/rxtx_switch_sequencer.sv
// RX/TX antenna-switch sequencer: mutes, switches and settles the RF path
// around transmit, applies frequency updates only in stable states, TX watchdog.
module rxtx_switch_sequencer
   import stm32_if_pkg::*;
#(
   parameter int unsigned MUTE_CYCLES   = 16,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned TX_TIMEOUT    = 4800000
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              params_valid,
   input  logic              tx_req,
   input  logic              preamp_req,
   input  logic [FREQ_W-1:0] freq_req,
   output logic              rx,
   output logic              tx,
   output logic              preamp_enable,
   output logic [FREQ_W-1:0] freq_out,
   output logic              rx_mute,
   output logic              tx_iq_en,
   output logic              busy,
   output logic              timeout_flag,
   output logic [2:0]        state_debug
);

   localparam logic [TMR_W-1:0]  MUTE_LD   = TMR_W'(MUTE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TX_TIMEOUT - 1);

   seq_state_e        state_q, state_d;
   logic              tx_lat_q, pre_lat_q, pre_lat_d;
   logic [FREQ_W-1:0] freq_pend_q;
   logic              pend_q;
   logic [WDOG_W-1:0] wdog_q;
   logic              tmr_load, tmr_zero;
   logic [TMR_W-1:0]  tmr_val;
   logic              wdog_refresh, wdog_expire, flag_clear;
   logic              stable_q, stable_d;

   seq_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      wdog_refresh = params_valid & tx_req;
      flag_clear   = params_valid & ~tx_req;
      wdog_expire  = (state_q == StTx) && (wdog_q == WDOG_LAST) && !wdog_refresh;
      pre_lat_d    = params_valid ? preamp_req : pre_lat_q;
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_val      = MUTE_LD;
      case (state_q)
         StRx: begin
            if (tx_lat_q && !timeout_flag) begin
               state_d  = StRxMute;
               tmr_load = 1'b1;
            end
         end
         StRxMute: begin
            if (tmr_zero) begin
               state_d  = StTxSettle;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LD;
            end
         end
         StTxSettle: begin
            if (!tx_lat_q) begin
               state_d  = StRxSettle;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LD;
            end else if (tmr_zero) begin
               state_d = StTx;
            end
         end
         StTx: begin
            if (!tx_lat_q || wdog_expire) begin
               state_d  = StTxDrain;
               tmr_load = 1'b1;
            end
         end
         StTxDrain: begin
            if (tmr_zero) begin
               state_d  = StRxSettle;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LD;
            end
         end
         StRxSettle: begin
            if (tmr_zero) begin
               state_d = StRx;
            end
         end
         default: state_d = StRx;
      endcase
      stable_q = (state_q == StRx) || (state_q == StTx);
      stable_d = (state_d == StRx) || (state_d == StTx);
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q       <= StRx;
         tx_lat_q      <= 1'b0;
         pre_lat_q     <= 1'b0;
         freq_pend_q   <= '0;
         pend_q        <= 1'b0;
         wdog_q        <= '0;
         timeout_flag  <= 1'b0;
         rx            <= 1'b1;
         tx            <= 1'b0;
         preamp_enable <= 1'b0;
         freq_out      <= FREQ_DEFAULT;
         rx_mute       <= 1'b0;
         tx_iq_en      <= 1'b0;
         busy          <= 1'b0;
         state_debug   <= 3'd0;
      end else begin
         state_q   <= state_d;
         pre_lat_q <= pre_lat_d;
         if (params_valid) begin
            tx_lat_q    <= tx_req;
            freq_pend_q <= freq_req;
         end

         // Frequency changes land only in RX/TX; a strobe on the entry edge beats the pending word.
         if (stable_q) begin
            if (params_valid) freq_out <= freq_req;
            pend_q <= 1'b0;
         end else if (stable_d) begin
            if (params_valid) begin
               freq_out <= freq_req;
            end else if (pend_q) begin
               freq_out <= freq_pend_q;
            end
            pend_q <= 1'b0;
         end else if (params_valid) begin
            pend_q <= 1'b1;
         end

         if ((state_q == StTx) && (state_d == StTx)) begin
            wdog_q <= wdog_refresh ? '0 : wdog_q + WDOG_W'(1);
         end else begin
            wdog_q <= '0;
         end

         if (flag_clear) begin
            timeout_flag <= 1'b0;
         end else if (wdog_expire) begin
            timeout_flag <= 1'b1;
         end

         rx            <= (state_d == StRx) || (state_d == StRxMute) || (state_d == StRxSettle);
         tx            <= (state_d == StTxSettle) || (state_d == StTx) || (state_d == StTxDrain);
         rx_mute       <= (state_d != StRx);
         tx_iq_en      <= (state_d == StTx);
         busy          <= is_busy(state_d);
         preamp_enable <= ((state_d == StRx) || (state_d == StRxMute)) & pre_lat_d;
         state_debug   <= state_d;
      end
   end

endmodule

// File: doc/rxtx_switch_sequencer.md
RXTX_SWITCH_SEQUENCER -- requirements
Module: rxtx_switch_sequencer

Interface
REQ-001 Parameter MUTE_CYCLES, 16, cycles spent in RX_MUTE and in TX_DRAIN.
REQ-002 Parameter SETTLE_CYCLES, 64, cycles spent in TX_SETTLE and in RX_SETTLE.
REQ-003 Parameter TX_TIMEOUT, 4800000, TX watchdog limit in clk_in cycles; the counter is 24 bits wide.
REQ-004 clk_in  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 params_valid  input  1  one-cycle strobe; a new tx_req/preamp_req/freq_req set is valid.
REQ-007 tx_req, preamp_req  input  1 each  requested transmit mode; requested preamp state.
REQ-008 freq_req  input  22  requested NCO frequency word.
REQ-009 rx, tx  output  1 each  registered RF path selects.
REQ-010 preamp_enable  output  1  LNA enable.
REQ-011 freq_out  output  22  applied NCO frequency word.
REQ-012 rx_mute  output  1  forces DDC IQ to zero downstream.
REQ-013 tx_iq_en  output  1  passes TX IQ to the DAC.
REQ-014 busy  output  1  high in any transitional state.
REQ-015 timeout_flag  output  1  sticky watchdog indication.
REQ-016 state_debug  output  3  current state encoding.

Function
REQ-017 On the params_valid edge, tx_req, preamp_req and freq_req SHALL be latched into tx_lat, pre_lat and a pending frequency register; the FSM SHALL react to tx_lat on the following edge.
REQ-018 States and encodings SHALL be: RX=0, RX_MUTE=1, TX_SETTLE=2, TX=3, TX_DRAIN=4, RX_SETTLE=5.
REQ-019 Each timed state SHALL load its counter with N-1 on entry and exit on the edge where the counter is 0, so the state lasts exactly N cycles.
REQ-020 RX: rx=1, tx=0, rx_mute=0, tx_iq_en=0. RX SHALL go to RX_MUTE when tx_lat=1 and timeout_flag=0.
REQ-021 RX_MUTE (MUTE_CYCLES): rx=1, tx=0, rx_mute=1. Exit SHALL go to TX_SETTLE.
REQ-022 TX_SETTLE (SETTLE_CYCLES): rx=0, tx=1, rx_mute=1, tx_iq_en=0. Exit SHALL go to TX. If tx_lat=0 at any cycle, the FSM SHALL go to RX_SETTLE instead (abort).
REQ-023 TX: rx=0, tx=1, tx_iq_en=1. The FSM SHALL go to TX_DRAIN on tx_lat=0 or on watchdog expiry.
REQ-024 TX_DRAIN (MUTE_CYCLES): tx=1, tx_iq_en=0. Exit SHALL go to RX_SETTLE.
REQ-025 RX_SETTLE (SETTLE_CYCLES): rx=1, tx=0, rx_mute=1. Exit SHALL go to RX; tx_lat=1 during RX_SETTLE is acted on only after reaching RX.
REQ-026 rx and tx SHALL never be simultaneously 1, and tx_iq_en=1 SHALL occur only in TX.
REQ-027 preamp_enable SHALL equal pre_lat in RX and RX_MUTE, and SHALL be 0 in all other states.
REQ-028 params_valid in RX or TX SHALL update freq_out on the same edge. In transitional states the update SHALL be deferred and applied on the edge that enters RX or TX. A strobe coinciding with that entry edge SHALL win.
REQ-029 The watchdog SHALL count each cycle in TX, clear on params_valid with tx_req=1, and clear on leaving TX.
REQ-030 At count TX_TIMEOUT-1 with no refresh, the block SHALL set timeout_flag and go to TX_DRAIN.
REQ-031 timeout_flag SHALL clear only on params_valid with tx_req=0; while it is set, RX SHALL ignore tx_lat.
REQ-032 busy SHALL be 1 in states 1, 2, 4 and 5.

Reset
REQ-033 reset_in SHALL immediately force state=RX, rx=1, tx=0, preamp_enable=0, freq_out=620407, rx_mute=0, tx_iq_en=0, busy=0, timeout_flag=0, all latches 0, and all counters 0. Assertion mid-transition SHALL abort the transition to RX with no intermediate output.

Structure
REQ-034 A shared package stm32_if_pkg SHALL hold the state encoding, FREQ_W=22, and FREQ_DEFAULT=620407, shared with the STM32 bus interface.
REQ-035 A single sub-module seq_timer (loadable down-counter with zero flag) SHALL be used for the MUTE/SETTLE timing; the watchdog stays inline.

Verification (MUTE=4, SETTLE=8, TX_TIMEOUT=100)
REQ-036 Reset, then params_valid with tx_req=1 -> RX_MUTE for 4 cycles, TX_SETTLE for 8, then tx_iq_en=1 at cycle 14 after the strobe; rx and tx never both 1.
REQ-037 tx_req=0 at cycle 3 of TX_SETTLE -> RX_SETTLE next cycle, tx_iq_en never asserts, RX after 8 cycles.
REQ-038 TX held with no refresh -> timeout_flag=1 and TX_DRAIN after 100 cycles; a later tx_req=1 strobe is ignored; a tx_req=0 strobe clears the flag.
REQ-039 freq_req=0x3FFFFF strobed in TX_DRAIN -> freq_out unchanged until the RX entry edge, then 0x3FFFFF; preamp_req=1 -> preamp_enable=1 only in RX.
REQ-040 reset_in asserted mid TX_SETTLE -> outputs at reset values immediately, state_debug=0, freq_out=620407.
